// File: rtl/led_ram_arbiter.sv
// Shares the LED RAM address/data port between scan reads, pen writes and a
// built-in frame-clear engine; scan reads always win, clear beats pen.
module led_ram_arbiter #(
  parameter int CELLS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_req,
  input  logic [7:0] scan_row,
  input  logic [7:0] scan_col,
  input  logic       pen_req,
  input  logic [7:0] pen_row,
  input  logic [7:0] pen_col,
  input  logic [3:0] pen_data,
  output logic       pen_ack,
  output logic       pen_err,
  input  logic       clear_start,
  input  logic [3:0] clear_data,
  output logic       clear_busy,
  output logic       clear_done,
  output logic [7:0] ram_row,
  output logic [7:0] ram_col,
  output logic       ram_we,
  output logic [3:0] ram_data
);

  localparam logic [5:0] LastCell = 6'(CELLS - 1);

  // FINISH is the one cycle after the last clear write, where done pulses.
  typedef enum logic [1:0] {IDLE, CLEAR, FINISH} state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] clrData_q, clrData_d;
  logic [7:0] ramRow_q, ramRow_d;
  logic [7:0] ramCol_q, ramCol_d;
  logic [3:0] ramData_q, ramData_d;
  logic       ramWe_q, ramWe_d;
  logic       penAck_q, penAck_d;
  logic       penErr_q, penErr_d;
  logic       clearBusy_q, clearBusy_d;
  logic       clearDone_q, clearDone_d;

  logic       clearSlot;
  logic [5:0] slotCnt;
  logic [3:0] slotData;

  function automatic logic isOneHot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clrData_d   = clrData_q;
    ramRow_d    = ramRow_q;
    ramCol_d    = ramCol_q;
    ramData_d   = ramData_q;
    ramWe_d     = 1'b0;
    penAck_d    = 1'b0;
    penErr_d    = 1'b0;
    clearBusy_d = clearBusy_q;
    clearDone_d = 1'b0;
    clearSlot   = 1'b0;
    slotCnt     = cnt_q;
    slotData    = clrData_q;

    // The accepting cycle already competes for cell 0 using the live clear_data.
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d     = CLEAR;
          clearBusy_d = 1'b1;
          cnt_d       = 6'd0;
          clrData_d   = clear_data;
          slotCnt     = 6'd0;
          slotData    = clear_data;
          clearSlot   = 1'b1;
        end
      end
      CLEAR: clearSlot = 1'b1;
      FINISH: begin
        state_d     = IDLE;
        clearBusy_d = 1'b0;
        clearDone_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (scan_req) begin
      ramRow_d = scan_row;
      ramCol_d = scan_col;
    end else if (clearSlot) begin
      ramRow_d  = 8'h01 << slotCnt[5:3];
      ramCol_d  = 8'h01 << slotCnt[2:0];
      ramData_d = slotData;
      ramWe_d   = 1'b1;
      cnt_d     = slotCnt + 6'd1;
      if (slotCnt == LastCell) state_d = FINISH;
    end else if (state_q == IDLE && pen_req && !penAck_q) begin
      penAck_d = 1'b1;
      if (isOneHot(pen_row) && isOneHot(pen_col)) begin
        ramRow_d  = pen_row;
        ramCol_d  = pen_col;
        ramData_d = pen_data;
        ramWe_d   = 1'b1;
      end else begin
        penErr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      clrData_q   <= 4'd0;
      ramRow_q    <= 8'd0;
      ramCol_q    <= 8'd0;
      ramData_q   <= 4'd0;
      ramWe_q     <= 1'b0;
      penAck_q    <= 1'b0;
      penErr_q    <= 1'b0;
      clearBusy_q <= 1'b0;
      clearDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clrData_q   <= clrData_d;
      ramRow_q    <= ramRow_d;
      ramCol_q    <= ramCol_d;
      ramData_q   <= ramData_d;
      ramWe_q     <= ramWe_d;
      penAck_q    <= penAck_d;
      penErr_q    <= penErr_d;
      clearBusy_q <= clearBusy_d;
      clearDone_q <= clearDone_d;
    end
  end

  assign ram_row    = ramRow_q;
  assign ram_col    = ramCol_q;
  assign ram_we     = ramWe_q;
  assign ram_data   = ramData_q;
  assign pen_ack    = penAck_q;
  assign pen_err    = penErr_q;
  assign clear_busy = clearBusy_q;
  assign clear_done = clearDone_q;

endmodule
